spike_rate_decoder: RTL and testbench

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

---
 rtl/lif_pkg.sv | 22 ++
 rtl/lif_rate_scale.sv | 40 ++++
 rtl/spike_rate_decoder.sv | 117 +++++++++++
 tb/tb_spike_rate_decoder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared fixed-point types, saturation helpers and FSM state encoding for the LIF blocks
// (lif_neuron, spike_rate_decoder).
package lif_pkg;

    localparam int unsigned FRAC_WIDTH = 8;

    typedef logic signed [15:0] q8_8_t;
    typedef logic signed [7:0]  q4_4_t;

    typedef logic [0:0] state_t;
    localparam state_t StIdle  = 1'b0;
    localparam state_t StCount = 1'b1;

    function automatic logic signed [63:0] sat_max(input int unsigned width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int unsigned width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/lif_rate_scale.sv
// Saturating count-to-rate scaler: rate = (count * gain) >>> (FRAC_WIDTH - OUT_FRAC_WIDTH),
// clamped to the signed OUT_WIDTH range.
module lif_rate_scale
    import lif_pkg::*;
#(
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned OUT_WIDTH      = 8,
    parameter int unsigned OUT_FRAC_WIDTH = 4
) (
    input  logic [CNT_WIDTH-1:0]        count,
    input  q8_8_t                       gain,
    output logic signed [OUT_WIDTH-1:0] rate
);

    localparam int unsigned ProdW = CNT_WIDTH + 17;
    localparam int unsigned Shift = FRAC_WIDTH - OUT_FRAC_WIDTH;
    localparam logic signed [63:0] RateMax = sat_max(OUT_WIDTH);
    localparam logic signed [63:0] RateMin = sat_min(OUT_WIDTH);

    logic signed [ProdW-1:0] count_ext;
    logic signed [ProdW-1:0] gain_ext;
    logic signed [ProdW-1:0] prod;
    logic signed [63:0]      shifted;

    // Count is unsigned, so zero-extend it before the signed multiply.
    assign count_ext = $signed({{17{1'b0}}, count});
    assign gain_ext  = ProdW'(gain);
    assign prod      = count_ext * gain_ext;
    assign shifted   = 64'(prod >>> Shift);

    always_comb begin
        rate = shifted[OUT_WIDTH-1:0];
        if (shifted > RateMax) begin
            rate = RateMax[OUT_WIDTH-1:0];
        end else if (shifted < RateMin) begin
            rate = RateMin[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike-count rate decoder with a valid/ready result register.
// Define SPIKE_DEC_ISI_EN to add the last_isi inter-spike-interval output.
module spike_rate_decoder
    import lif_pkg::*;
#(
    parameter int unsigned WINDOW_LEN     = 256,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned OUT_WIDTH      = 8,
    parameter int unsigned OUT_FRAC_WIDTH = 4,
    parameter int signed   GAIN           = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        spike,
    output logic signed [OUT_WIDTH-1:0] rate_out,
    output logic                        rate_valid,
    input  logic                        rate_ready,
    output logic                        overrun,
    output logic                        busy
`ifdef SPIKE_DEC_ISI_EN
    ,
    output logic [CNT_WIDTH-1:0]        last_isi
`endif
);

    localparam int unsigned WinW = $clog2(WINDOW_LEN);
    localparam logic [WinW-1:0]      WinLast = WinW'(WINDOW_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CntMax  = '1;
    localparam q8_8_t                GainQ   = q8_8_t'(GAIN);

    state_t                      state_q, state_d;
    logic [WinW-1:0]             win_q, win_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d, cnt_inc;
    logic                        active, load;
    logic signed [OUT_WIDTH-1:0] scaled;
    logic signed [OUT_WIDTH-1:0] rate_out_d;
    logic                        rate_valid_d, overrun_d;

    assign active  = (state_q == StCount) && enable;
    assign load    = active && (win_q == WinLast);
    assign cnt_inc = (spike && (cnt_q != CntMax)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    assign busy    = (state_q == StCount);

    lif_rate_scale #(
        .CNT_WIDTH      (CNT_WIDTH),
        .OUT_WIDTH      (OUT_WIDTH),
        .OUT_FRAC_WIDTH (OUT_FRAC_WIDTH)
    ) u_scale (
        .count (cnt_inc),
        .gain  (GainQ),
        .rate  (scaled)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (enable)  state_d = StCount;
            StCount: if (!enable) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Counters fall back to zero in IDLE, on abort and at window end.
        win_d = '0;
        cnt_d = '0;
        if (active && !load) begin
            win_d = win_q + WinW'(1);
            cnt_d = cnt_inc;
        end

        // A same-cycle handshake consumes the old value, so no overrun then.
        rate_out_d   = load ? scaled : rate_out;
        rate_valid_d = load || (rate_valid && !rate_ready);
        overrun_d    = load && rate_valid && !rate_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            win_q      <= '0;
            cnt_q      <= '0;
            rate_out   <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            rate_out   <= rate_out_d;
            rate_valid <= rate_valid_d;
            overrun    <= overrun_d;
        end
    end

`ifdef SPIKE_DEC_ISI_EN
    logic [CNT_WIDTH-1:0] isi_q;
    logic                 isi_armed_q;

    // The first spike after IDLE only arms the interval timer.
    always_ff @(posedge clk) begin
        if (rst || !active) begin
            isi_q       <= '0;
            isi_armed_q <= 1'b0;
            last_isi    <= '0;
        end else if (spike) begin
            if (isi_armed_q) begin
                last_isi <= isi_q;
            end
            isi_q       <= CNT_WIDTH'(1);
            isi_armed_q <= 1'b1;
        end else if (isi_armed_q && (isi_q != CntMax)) begin
            isi_q <= isi_q + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: a table of whole-window spike masks plus
// hand-written overrun, handshake, abort and reset sequences.
module tb_spike_rate_decoder;

    logic clk = 1'b0;
    logic rst, enable, spike, rate_ready;
    logic signed [7:0] rate_out, neg_rate, sat_rate;
    logic rate_valid, overrun, busy;
    logic neg_valid, neg_overrun, neg_busy;
    logic sat_valid, sat_overrun, sat_busy;
`ifdef SPIKE_DEC_ISI_EN
    logic [15:0] last_isi, neg_isi;
    logic [1:0]  sat_isi;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spike_rate_decoder #(
        .WINDOW_LEN (16),
        .GAIN       (256)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .spike      (spike),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .overrun    (overrun),
        .busy       (busy)
`ifdef SPIKE_DEC_ISI_EN
        ,
        .last_isi   (last_isi)
`endif
    );

    // Negative gain, 2-cycle window: any spike in the last two cycles saturates low.
    spike_rate_decoder #(
        .WINDOW_LEN (2),
        .GAIN       (-4096)
    ) dut_neg (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .spike      (spike),
        .rate_out   (neg_rate),
        .rate_valid (neg_valid),
        .rate_ready (1'b1),
        .overrun    (neg_overrun),
        .busy       (neg_busy)
`ifdef SPIKE_DEC_ISI_EN
        ,
        .last_isi   (neg_isi)
`endif
    );

    // 2-bit counter, 8-cycle window: spike count saturates at 3.
    spike_rate_decoder #(
        .WINDOW_LEN (8),
        .CNT_WIDTH  (2),
        .GAIN       (256)
    ) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .spike      (spike),
        .rate_out   (sat_rate),
        .rate_valid (sat_valid),
        .rate_ready (1'b1),
        .overrun    (sat_overrun),
        .busy       (sat_busy)
`ifdef SPIKE_DEC_ISI_EN
        ,
        .last_isi   (sat_isi)
`endif
    );

    typedef struct {
        logic [15:0] mask;
        int          main_rate;
        int          neg_rate;
        int          sat_rate;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic s);
        spike = s;
        @(negedge clk);
    endtask

    task automatic run_window(input logic [15:0] mask, input logic ready_last);
        for (int i = 0; i < 16; i++) begin
            if (ready_last && i == 15) rate_ready = 1'b1;
            step(mask[i]);
            if (ready_last && i == 15) rate_ready = 1'b0;
        end
        spike = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h8421,   64, -128, 32};
        vecs[1] = '{16'hFFFF,  127, -128, 48};
        vecs[2] = '{16'h0000,    0,    0,  0};
        vecs[3] = '{16'h0001,   16,    0,  0};
        vecs[4] = '{16'h0007,   48,    0,  0};
        vecs[5] = '{16'h00FF,  127,    0,  0};
        vecs[6] = '{16'h007F,  112,    0,  0};
        vecs[7] = '{16'h8000,   16, -128, 16};
        vecs[8] = '{16'h4000,   16, -128, 16};
        vecs[9] = '{16'hFF00,  127, -128, 48};

        rst = 1'b1; enable = 1'b0; spike = 1'b0; rate_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset rate_out", rate_out, 0);
        check("reset rate_valid", rate_valid, 0);
        check("reset overrun", overrun, 0);
        check("reset busy", busy, 0);
        rst = 1'b0;
        step(1'b0);
        check("idle busy", busy, 0);

        // Back-to-back windows, consumer always ready.
        rate_ready = 1'b1;
        enable = 1'b1;
        step(1'b0);
        check("start busy", busy, 1);
        for (int v = 0; v < 10; v++) begin
            run_window(vecs[v].mask, 1'b0);
            check($sformatf("vec%0d rate_out", v), rate_out, vecs[v].main_rate);
            check($sformatf("vec%0d rate_valid", v), rate_valid, 1);
            check($sformatf("vec%0d overrun", v), overrun, 0);
            check($sformatf("vec%0d neg_rate", v), neg_rate, vecs[v].neg_rate);
            check($sformatf("vec%0d sat_rate", v), sat_rate, vecs[v].sat_rate);
        end

        // Stop, drain, restart.
        enable = 1'b0;
        step(1'b0);
        rate_ready = 1'b0;
        check("drain rate_valid", rate_valid, 0);
        check("stop busy", busy, 0);
        enable = 1'b1;
        step(1'b0);

        // Overrun: two windows with nobody consuming.
        run_window(16'h0003, 1'b0);
        check("ovr w1 rate_out", rate_out, 32);
        check("ovr w1 overrun", overrun, 0);
        run_window(16'h0007, 1'b0);
        check("ovr w2 rate_out", rate_out, 48);
        check("ovr w2 rate_valid", rate_valid, 1);
        check("ovr w2 overrun", overrun, 1);
        enable = 1'b0;
        step(1'b0);
        check("ovr pulse ends", overrun, 0);
        check("ovr abort keeps valid", rate_valid, 1);
        check("ovr abort keeps rate", rate_out, 48);
        check("ovr abort busy", busy, 0);

        // Handshake exactly on the load cycle of window 2.
        rate_ready = 1'b1;
        step(1'b0);
        rate_ready = 1'b0;
        check("hs drained", rate_valid, 0);
        enable = 1'b1;
        step(1'b0);
        run_window(16'h0001, 1'b0);
        check("hs w1 rate_out", rate_out, 16);
        run_window(16'h0003, 1'b1);
        check("hs w2 rate_out", rate_out, 32);
        check("hs w2 rate_valid", rate_valid, 1);
        check("hs w2 overrun", overrun, 0);

        // Abort at window cycle 7 after 3 spikes; the partial count must be dropped.
        enable = 1'b0;
        rate_ready = 1'b1;
        step(1'b0);
        rate_ready = 1'b0;
        enable = 1'b1;
        step(1'b0);
        for (int i = 0; i < 7; i++) step(i < 3);
        enable = 1'b0;
        step(1'b0);
        check("abort busy", busy, 0);
        check("abort no result", rate_valid, 0);
        enable = 1'b1;
        step(1'b0);
        run_window(16'h0010, 1'b0);
        check("abort new rate_out", rate_out, 16);
        check("abort new rate_valid", rate_valid, 1);

        // Reset mid-window with a pending result.
        for (int i = 0; i < 5; i++) step(1'b1);
        rst = 1'b1;
        step(1'b0);
        check("rst rate_out", rate_out, 0);
        check("rst rate_valid", rate_valid, 0);
        check("rst overrun", overrun, 0);
        check("rst busy", busy, 0);
`ifdef SPIKE_DEC_ISI_EN
        check("rst last_isi", last_isi, 0);
`endif
        rst = 1'b0;
        step(1'b0);
        check("post-rst busy", busy, 1);
        for (int i = 0; i < 10; i++) step(i == 2 || i == 9);
`ifdef SPIKE_DEC_ISI_EN
        check("isi 2->9", last_isi, 7);
`endif
        check("post-rst no result", rate_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
